// File: rtl/mole_scorer.sv
// mole_scorer: button sync/edge detect, hit/miss judging, score/lives and IDLE/PLAY/OVER control.
// Optional macro WRONG_PRESS_PENALTY_EN: a press on an unlit or unarmed mole costs a life.
module mole_scorer #(
  parameter int SCORE_W = 8,
  parameter int LIVES   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [8:0]         lights,
  input  logic [8:0]         buttons,
  output logic [8:0]         hit_clear,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic               hit,
  output logic               miss,
  output logic               playing,
  output logic               game_over
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] OVER = 2'd2;
  localparam logic [SCORE_W+3:0] SCORE_MAX = {4'd0, {SCORE_W{1'b1}}};

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d, lives_n;
  logic [8:0]         armed_q, armed_d, lights_q;
  logic [8:0]         s1_q, s2_q, s3_q;
  logic [8:0]         hit_clear_q, press, rise, fall, hits, misses, wrong;
  logic               hit_q, miss_q, play, enter;
  logic [SCORE_W+3:0] sum;
  logic [4:0]         loss;

  function automatic logic [3:0] popcnt(input logic [8:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < 9; k++) c = c + {3'd0, v[k]};
    return c;
  endfunction

  always_comb begin
    press  = s2_q & ~s3_q;
    rise   = lights & ~lights_q;
    fall   = ~lights & lights_q;
    play   = state_q == PLAY;
    enter  = start && !play;
    hits   = play ? press & lights & armed_q : 9'd0;
    misses = play ? fall & armed_q : 9'd0;
`ifdef WRONG_PRESS_PENALTY_EN
    wrong  = play ? press & ~(lights & armed_q) & ~fall : 9'd0;
`else
    wrong  = 9'd0;
`endif
    sum     = {4'd0, score_q} + {{SCORE_W{1'b0}}, popcnt(hits)};
    loss    = {1'b0, popcnt(misses)} + {1'b0, popcnt(wrong)};
    lives_n = loss >= {1'b0, lives_q} ? 4'd0 : lives_q - loss[3:0];
    state_d = enter ? PLAY : (play && lives_n == 4'd0) ? OVER : state_q;
    score_d = enter ? '0 : play ? (sum > SCORE_MAX ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0]) : score_q;
    lives_d = enter ? 4'(LIVES) : play ? lives_n : lives_q;
    armed_d = enter ? 9'd0 : play ? (armed_q | rise) & ~hits & ~misses : armed_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      score_q     <= '0;
      lives_q     <= 4'(LIVES);
      armed_q     <= '0;
      lights_q    <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      hit_clear_q <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      armed_q     <= armed_d;
      lights_q    <= lights;
      s1_q        <= buttons;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      hit_clear_q <= hits;
      hit_q       <= |hits;
      miss_q      <= |(misses | wrong);
    end
  end

  assign hit_clear = hit_clear_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign playing   = state_q == PLAY;
  assign game_over = state_q == OVER;
endmodule

// File: tb/tb_mole_scorer.sv
// tb_mole_scorer: directed vectors for mole_scorer; second instance with SCORE_W=2 covers saturation.
module tb_mole_scorer;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [8:0] lights, buttons;
  logic [8:0] hit_clear, hit_clear2;
  logic [7:0] score;
  logic [1:0] score2;
  logic [3:0] lives, lives2;
  logic       hit, miss, playing, game_over;
  logic       hit2, miss2, playing2, game_over2;
  int         vectors = 0;
  int         errors = 0;

  mole_scorer #(.SCORE_W(8), .LIVES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .lights(lights), .buttons(buttons),
    .hit_clear(hit_clear), .score(score), .lives(lives), .hit(hit), .miss(miss),
    .playing(playing), .game_over(game_over)
  );

  mole_scorer #(.SCORE_W(2), .LIVES(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .lights(lights), .buttons(buttons),
    .hit_clear(hit_clear2), .score(score2), .lives(lives2), .hit(hit2), .miss(miss2),
    .playing(playing2), .game_over(game_over2)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arms mole i, presses it and checks the registered hit; leaves it cleaned up.
  task automatic do_hit(input int i, input logic [7:0] exp_score);
    lights[i] = 1'b1;
    step(2);
    buttons[i] = 1'b1;
    step(2);
    check("hit_pre", {31'd0, hit}, 0);
    step();
    check("hit_pulse", {31'd0, hit}, 1);
    check("hit_score", {24'd0, score}, {24'd0, exp_score});
    buttons[i] = 1'b0;
    lights[i] = 1'b0;
    step(3);
  endtask

  task automatic do_miss(input int i, input logic [3:0] exp_lives);
    lights[i] = 1'b1;
    step();
    lights[i] = 1'b0;
    step();
    check("miss_pulse", {31'd0, miss}, 1);
    check("miss_lives", {28'd0, lives}, {28'd0, exp_lives});
    step();
    check("miss_clear", {31'd0, miss}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; lights = '0; buttons = '0;
    step();
    check("rst_playing", {31'd0, playing}, 0);
    check("rst_over", {31'd0, game_over}, 0);
    check("rst_score", {24'd0, score}, 0);
    check("rst_lives", {28'd0, lives}, 3);
    check("rst_pulses", {21'd0, hit_clear, hit, miss}, 0);
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_playing", {31'd0, playing}, 1);
    check("start_lives", {28'd0, lives}, 3);

    lights[4] = 1'b1;
    step(6);
    buttons[4] = 1'b1;
    step(2);
    check("h4_early", {31'd0, hit}, 0);
    step();
    check("h4_hit", {31'd0, hit}, 1);
    check("h4_clear", {23'd0, hit_clear}, 32'h010);
    check("h4_score", {24'd0, score}, 1);
    step();
    check("h4_one_pulse", {22'd0, hit_clear, hit}, 0);
    step(3);
    check("h4_held", {24'd0, score}, 1);
    buttons[4] = 1'b0;
    lights[4] = 1'b0;
    step(2);
    check("h4_no_miss", {27'd0, miss, lives}, 3);
    step(2);

    do_miss(2, 4'd2);
    do_miss(2, 4'd1);
    lights[2] = 1'b1;
    step();
    lights[2] = 1'b0;
    step();
    check("over_lives", {28'd0, lives}, 0);
    check("over_flag", {31'd0, game_over}, 1);
    check("over_playing", {31'd0, playing}, 0);
    check("over_miss", {31'd0, miss}, 1);
    lights[4] = 1'b1;
    step();
    buttons[4] = 1'b1;
    step(4);
    check("over_ignore", {19'd0, score, lives, hit}, {19'd0, 8'd1, 4'd0, 1'b0});
    buttons[4] = 1'b0;
    lights[4] = 1'b0;
    step(3);

    start = 1'b1;
    step();
    start = 1'b0;
    check("restart", {22'd0, score, playing, game_over}, {22'd0, 8'd0, 1'b1, 1'b0});
    check("restart_lives", {28'd0, lives}, 3);

    lights[7] = 1'b1;
    step(3);
    buttons[7] = 1'b1;
    step(2);
    lights[7] = 1'b0;
    step();
    check("coll_miss", {31'd0, miss}, 1);
    check("coll_hit", {31'd0, hit}, 0);
    check("coll_score", {24'd0, score}, 0);
    check("coll_lives", {28'd0, lives}, 2);
    buttons[7] = 1'b0;
    step(3);

    lights = 9'h101;
    step(2);
    buttons = 9'h101;
    step(3);
    check("dbl_clear", {23'd0, hit_clear}, 32'h101);
    check("dbl_score", {24'd0, score}, 2);
    check("dbl_sat", {30'd0, score2}, 2);
    buttons = '0;
    lights = '0;
    step(3);
    check("dbl_lives", {28'd0, lives}, 2);

    buttons[1] = 1'b1;
    step(3);
`ifdef WRONG_PRESS_PENALTY_EN
    check("wrong_miss", {31'd0, miss}, 1);
    check("wrong_lives", {28'd0, lives}, 1);
`else
    check("wrong_miss", {31'd0, miss}, 0);
    check("wrong_lives", {28'd0, lives}, 2);
`endif
    buttons[1] = 1'b0;
    step(3);

    do_hit(3, 8'd3);
    check("sat_at_max", {30'd0, score2}, 3);
    do_hit(5, 8'd4);
    do_hit(6, 8'd5);
    check("sat_held", {30'd0, score2}, 3);
    check("sat_main", {24'd0, score}, 5);

    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst", {19'd0, score, lives, playing}, {19'd0, 8'd0, 4'd3, 1'b0});
    check("midrst_sat", {30'd0, score2}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
